// File: rtl/regmux_pkg.sv
// Shared widths and types for the register-read mux arbiter.
package regmux_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_DATA_W = 32;
    localparam int unsigned NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/rr_picker.sv
// Rotating priority picker: grants the first set request after last_grant,
// wrapping modulo NUM_REQ.
module rr_picker #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    idx,
    output logic               any
);

    int unsigned     cand;
    logic [ID_W-1:0] cand_idx;

    always_comb begin
        gnt      = '0;
        idx      = '0;
        any      = 1'b0;
        cand     = 0;
        cand_idx = '0;
        // Offsets 1..NUM_REQ visit every requester once, last_grant itself last.
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand     = (32'(last_grant) + off) % NUM_REQ;
            cand_idx = ID_W'(cand);
            if (!any && req[cand_idx]) begin
                any           = 1'b1;
                idx           = cand_idx;
                gnt[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regmux_read_arbiter.sv
// Round-robin arbiter sharing one 32:1 register-read mux among NUM_REQ requesters.
// Define REGMUX_ZERO_BYPASS_EN to make reads of register 0 return zero.
module regmux_read_arbiter
    import regmux_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = REG_ADDR_W,
    parameter int unsigned DATA_W  = REG_DATA_W,
    localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      port_stall,
    output logic [ADDR_W-1:0]         mux_sel,
    input  logic [DATA_W-1:0]         mux_data,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [ADDR_W-1:0]         rsp_addr,
    output logic [DATA_W-1:0]         rsp_data
);

    logic [NUM_REQ-1:0] pick_gnt;
    logic [ID_W-1:0]    pick_idx;
    logic               pick_any;
    logic               grant_en;
    logic               handshake;
    logic [ADDR_W-1:0]  sel;
    logic [DATA_W-1:0]  cap_data;

    logic [ID_W-1:0]    last_grant_q, last_grant_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
    logic [ADDR_W-1:0]  rsp_addr_q, rsp_addr_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .gnt        (pick_gnt),
        .idx        (pick_idx),
        .any        (pick_any)
    );

    // A borrowed port or reset suppresses the grant but not the search.
    assign grant_en  = pick_any & ~port_stall & ~rst;
    assign req_ready = grant_en ? pick_gnt : '0;
    assign handshake = |(req_valid & req_ready);

    always_comb begin
        sel = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                sel = sel | req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    assign mux_sel = sel;

`ifdef REGMUX_ZERO_BYPASS_EN
    // r0 is hardwired zero whatever the mux presents.
    assign cap_data = (sel == '0) ? '0 : mux_data;
`else
    assign cap_data = mux_data;
`endif

    always_comb begin
        last_grant_d = last_grant_q;
        rsp_valid_d  = 1'b0;
        rsp_id_d     = rsp_id_q;
        rsp_addr_d   = rsp_addr_q;
        rsp_data_d   = rsp_data_q;
        if (handshake) begin
            last_grant_d = pick_idx;
            rsp_valid_d  = 1'b1;
            rsp_id_d     = pick_idx;
            rsp_addr_d   = sel;
            rsp_data_d   = cap_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= ID_W'(NUM_REQ - 1);
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_addr_q   <= '0;
            rsp_data_q   <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_addr_q   <= rsp_addr_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_addr  = rsp_addr_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_regmux_read_arbiter.sv
// Scoreboard bench for regmux_read_arbiter: directed scenarios then random traffic
// against a round-robin reference model.
module tb_regmux_read_arbiter;
    import regmux_pkg::*;

    localparam int N = 4;

    typedef struct {
        int        due;
        int        id;
        reg_addr_t addr;
        reg_data_t data;
    } rsp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*5-1:0] req_addr;
    logic [N-1:0]   req_ready;
    logic           port_stall;
    logic [4:0]     mux_sel;
    logic [31:0]    mux_data;
    logic           rsp_valid;
    logic [1:0]     rsp_id;
    logic [4:0]     rsp_addr;
    logic [31:0]    rsp_data;

    reg_addr_t      addr_a [N];
    logic           force_dead;

    int             total = 0;
    int             bad = 0;
    int             cyc_n = 0;
    int             m_last = N - 1;
    logic [N-1:0]   granted = '0;
    rsp_t           sb[$];
    int             grant_log[$];
    reg_data_t      data_log[$];
    int             exp_g[$];
    reg_data_t      exp_d[$];

    regmux_read_arbiter u_dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .port_stall (port_stall),
        .mux_sel    (mux_sel),
        .mux_data   (mux_data),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_addr   (rsp_addr),
        .rsp_data   (rsp_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    always_comb begin
        req_addr = '0;
        for (int i = 0; i < N; i++) req_addr[i*5 +: 5] = addr_a[i];
    end

    // Register file model: register k holds k*0x11.
    assign mux_data = force_dead ? 32'hDEADBEEF : 32'(mux_sel) * 32'd17;

    function automatic int model_pick(input logic [N-1:0] v, input int last);
        int c;
        for (int k = 1; k <= N; k++) begin
            c = (last + k) % N;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic reg_data_t model_data(input reg_addr_t a, input logic dead);
        reg_data_t d;
        d = dead ? 32'hDEADBEEF : 32'(a) * 32'd17;
`ifdef REGMUX_ZERO_BYPASS_EN
        if (a == 5'd0) d = '0;
`endif
        return d;
    endfunction

    // Request side: predict grant and select, queue the expected response.
    always @(negedge clk) begin : b_req
        int           w;
        logic [N-1:0] er;
        reg_addr_t    es;
        rsp_t         it;
        if (cyc_n >= 1) begin
            w  = -1;
            er = '0;
            es = '0;
            if (!rst && !port_stall) w = model_pick(req_valid, m_last);
            if (w >= 0) begin
                er[w] = 1'b1;
                es    = addr_a[w];
            end
            total++;
            if (req_ready !== er) begin
                bad++;
                $display("FAIL req_ready cyc=%0d got=%b need=%b", cyc_n, req_ready, er);
            end
            total++;
            if (mux_sel !== es) begin
                bad++;
                $display("FAIL mux_sel cyc=%0d got=%0d need=%0d", cyc_n, mux_sel, es);
            end
            granted = er;
            if (w >= 0) begin
                it.due  = cyc_n + 1;
                it.id   = w;
                it.addr = es;
                it.data = model_data(es, force_dead);
                sb.push_back(it);
                grant_log.push_back(w);
                m_last = w;
            end
            if (rst) m_last = N - 1;
        end
    end

    // Response monitor: pops the scoreboard when a response is due.
    always @(negedge clk) begin : b_mon
        logic due;
        rsp_t it;
        rsp_t hold;
        if (cyc_n == 0) begin
            hold.due  = 0;
            hold.id   = 0;
            hold.addr = '0;
            hold.data = '0;
        end else begin
            due = 1'b0;
            if (sb.size() > 0) due = (sb[0].due == cyc_n);
            total++;
            if (rsp_valid !== due) begin
                bad++;
                $display("FAIL rsp_valid cyc=%0d got=%b need=%b", cyc_n, rsp_valid, due);
            end
            if (rsp_valid === 1'b1) data_log.push_back(rsp_data);
            if (due) begin
                it   = sb.pop_front();
                hold = it;
            end
            total++;
            if (int'(rsp_id) != hold.id || rsp_addr !== hold.addr || rsp_data !== hold.data) begin
                bad++;
                $display("FAIL rsp_fields cyc=%0d got id=%0d addr=%0d data=%h need id=%0d addr=%0d data=%h",
                         cyc_n, rsp_id, rsp_addr, rsp_data, hold.id, hold.addr, hold.data);
            end
            if (rst) begin
                hold.id   = 0;
                hold.addr = '0;
                hold.data = '0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Requesters hold until granted, then drop.
    task automatic cyc_drop();
        cyc();
        req_valid = req_valid & ~granted;
    endtask

    task automatic clear_logs();
        grant_log.delete();
        data_log.delete();
    endtask

    task automatic chk_logs(input string name);
        total++;
        if (grant_log.size() != exp_g.size()) begin
            bad++;
            $display("FAIL %s grant_count got=%0d need=%0d", name, grant_log.size(), exp_g.size());
        end else begin
            for (int i = 0; i < exp_g.size(); i++) begin
                total++;
                if (grant_log[i] != exp_g[i]) begin
                    bad++;
                    $display("FAIL %s grant[%0d] got=%0d need=%0d", name, i, grant_log[i], exp_g[i]);
                end
            end
        end
        total++;
        if (data_log.size() != exp_d.size()) begin
            bad++;
            $display("FAIL %s data_count got=%0d need=%0d", name, data_log.size(), exp_d.size());
        end else begin
            for (int i = 0; i < exp_d.size(); i++) begin
                total++;
                if (data_log[i] !== exp_d[i]) begin
                    bad++;
                    $display("FAIL %s data[%0d] got=%h need=%h", name, i, data_log[i], exp_d[i]);
                end
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        port_stall = 1'b0;
        force_dead = 1'b0;
        for (int i = 0; i < N; i++) addr_a[i] = '0;

        // Reset then idle.
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
        cyc();

        // Single request from requester 2.
        clear_logs();
        addr_a[2] = 5'd7;
        req_valid = 4'b0100;
        cyc_drop();
        cyc();
        cyc();
        exp_g = '{2};
        exp_d = '{32'h77};
        chk_logs("single");

        // All four requesting continuously from reset.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        clear_logs();
        addr_a[0] = 5'd1;
        addr_a[1] = 5'd2;
        addr_a[2] = 5'd3;
        addr_a[3] = 5'd4;
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) cyc();
        req_valid = '0;
        cyc();
        cyc();
        exp_g = '{0, 1, 2, 3, 0};
        exp_d = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h11};
        chk_logs("all_four");

        // Stall with requesters 1 and 3 pending.
        clear_logs();
        addr_a[1]  = 5'd5;
        addr_a[3]  = 5'd9;
        req_valid  = 4'b1010;
        port_stall = 1'b1;
        cyc();
        cyc();
        cyc();
        port_stall = 1'b0;
        cyc_drop();
        cyc_drop();
        cyc();
        cyc();
        exp_g = '{1, 3};
        exp_d = '{32'h55, 32'h99};
        chk_logs("stall");

        // Reset on the cycle after a handshake.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        clear_logs();
        addr_a[1] = 5'd2;
        addr_a[2] = 5'd6;
        req_valid = 4'b0110;
        cyc_drop();
        rst       = 1'b1;
        addr_a[0] = 5'd10;
        req_valid[0] = 1'b1;
        cyc();
        rst = 1'b0;
        cyc_drop();
        cyc_drop();
        cyc();
        cyc();
        exp_g = '{1, 0, 2};
        exp_d = '{32'h22, 32'hAA, 32'h66};
        chk_logs("reset_mid");

        // Read of register 0 with a corrupted mux output.
        clear_logs();
        addr_a[0]  = 5'd0;
        req_valid  = 4'b0001;
        force_dead = 1'b1;
        cyc_drop();
        force_dead = 1'b0;
        cyc();
        cyc();
        exp_g = '{0};
`ifdef REGMUX_ZERO_BYPASS_EN
        exp_d = '{32'h0};
`else
        exp_d = '{32'hDEADBEEF};
`endif
        chk_logs("zero_reg");

        // Random traffic.
        for (int t = 0; t < 2000; t++) begin
            cyc();
            for (int i = 0; i < N; i++) begin
                if (granted[i]) req_valid[i] = 1'b0;
                if (!req_valid[i] && $urandom_range(0, 99) < 40) begin
                    req_valid[i] = 1'b1;
                    addr_a[i]    = 5'($urandom_range(0, NUM_REGS - 1));
                end
            end
            port_stall = ($urandom_range(0, 99) < 15);
            force_dead = ($urandom_range(0, 99) < 10);
            rst        = ($urandom_range(0, 99) < 2);
        end

        rst        = 1'b0;
        port_stall = 1'b0;
        force_dead = 1'b0;
        req_valid  = '0;
        cyc();
        cyc();
        cyc();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d need=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regmux_read_arbiter.md
Name: regmux_read_arbiter

Overview:
Round-robin arbiter that shares the single 32-to-1 register-read mux (32 x 32-bit inputs, 5-bit select) among NUM_REQ read requesters, such as decode operand A/B and debug.
- Drives the mux select combinationally from the winning request.
- Registers the mux output into a one-cycle-latency response tagged with the requester ID.
- Sits between the register file and the decode/issue logic of the 32-bit processor.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 5, register address / mux select width
DATA_W, 32, register data width
ID_W, $clog2(NUM_REQ), derived localparam; not overridable

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
req_valid  input  NUM_REQ  per-requester read request
req_addr  input  NUM_REQ*ADDR_W  packed register addresses; requester i uses bits [i*ADDR_W +: ADDR_W]
req_ready  output  NUM_REQ  one-hot grant; handshake when req_valid[i] & req_ready[i]
port_stall  input  1  mux port borrowed elsewhere this cycle; no grant allowed
mux_sel  output  ADDR_W  select to the 32:1 mux
mux_data  input  DATA_W  mux output, combinational from mux_sel
rsp_valid  output  1  response valid, one-cycle pulse per handshake
rsp_id  output  ID_W  index of the requester being answered
rsp_addr  output  ADDR_W  address that was read
rsp_data  output  DATA_W  registered read data

Behaviour:
- Only one clock and one synchronous reset. At most one grant per cycle.
- State is held in `last_grant` (ID_W bits). The priority search starts at `last_grant+1` and wraps modulo NUM_REQ.
- `req_ready` (combinational):
  - One-hot on the first requester found in the search with `req_valid` set, when `port_stall`=0.
  - All zero when `port_stall`=1, when `rst`=1, or when no request is present.
- `mux_sel` = winner's `req_addr` when a grant is issued, else 0.
- On a handshake edge:
  - `rsp_valid` <= 1, `rsp_id` <= winner, `rsp_addr` <= `mux_sel`, `rsp_data` <= `mux_data`, `last_grant` <= winner.
  - Latency is exactly 1 cycle from handshake to `rsp_valid`.
- On a cycle with no handshake:
  - `rsp_valid` <= 0.
  - `rsp_id`, `rsp_addr`, `rsp_data` hold their previous values.
  - `last_grant` is unchanged, including under stall.
- Reset values: `rsp_valid`=0, `rsp_id`=0, `rsp_addr`=0, `rsp_data`=0, `last_grant`=NUM_REQ-1, so requester 0 wins first.
- Reset mid-operation: a response in flight is dropped; `rsp_valid` is 0 on the cycle after the reset edge.
- Requester rules:
  - Must hold `req_valid` and `req_addr` stable until granted.
  - A deasserted request is simply skipped.
  - The arbiter does not check for a changed address.
- Fairness: a continuously asserted request is granted within NUM_REQ cycles of non-stalled operation.
- Single requester active: granted every cycle, giving back-to-back `rsp_valid`.
- Wrap-around: after granting NUM_REQ-1, the search starts at 0.
- No response backpressure: consumers must accept `rsp_valid` when it pulses.

Optional Feature:
Macro REGMUX_ZERO_BYPASS_EN.
- Defined: a granted read with address 0 returns `rsp_data`=0 regardless of `mux_data`. Grant, latency and `rsp_id` are unchanged. This enforces the hardwired-zero register r0.
- Undefined: `rsp_data` is always the captured `mux_data`.

Decomposition:
- Package `regmux_pkg`: constants for the address and data widths (5, 32), the register count (32), and the `reg_addr_t` and `reg_data_t` typedefs.
- Sub-module `rr_picker`: a combinational rotate-and-priority-encode block.
  - Inputs: request vector and `last_grant`.
  - Outputs: one-hot grant, winner index, `any` flag.
- Top level: stall gating, select muxing, response registers, `last_grant` register.

Test Plan:
All scenarios use a mux model where input k = 32'h0000_00k0 + k, NUM_REQ=4.
- Reset then idle: `rst`=1 for 2 cycles, no requests -> `rsp_valid`=0, `mux_sel`=0, `req_ready`=0, `rsp_data`=0.
- Single request: requester 2 requests addr 5'd7 for one handshake -> `mux_sel`=7 that cycle; next cycle `rsp_valid`=1, `rsp_id`=2, `rsp_addr`=7, `rsp_data`=32'h77.
- All four requesting continuously, addrs 1, 2, 3, 4:
  - Grant order after reset is 0,1,2,3,0.
  - `rsp_data` sequence is 32'h11, 32'h22, 32'h33, 32'h44, 32'h11, with one response per cycle.
- Stall: requesters 1 and 3 pending, `port_stall`=1 for 3 cycles -> no `req_ready`, no `rsp_valid`, `last_grant` unchanged. After release, requester 1 then requester 3 are granted.
- Reset mid-flight: assert `rst` on the cycle after a handshake -> `rsp_valid`=0 the next cycle and `last_grant` returns to 3; the following grant goes to the lowest active requester.
- Zero bypass: request addr 0 with `mux_data` forced to 32'hDEADBEEF.
  - With REGMUX_ZERO_BYPASS_EN defined: `rsp_data`=0.
  - Without it: `rsp_data`=32'hDEADBEEF.
